// File: rtl/ad7763_pkg.sv
// Shared defaults and helpers for the AD7763 block-averaging decimator.
// Optional rounding is enabled by defining AD7763_AVG_ROUND_EN.
package ad7763_pkg;

  localparam int IN_WIDTH_DEF   = 24;
  localparam int OUT_WIDTH_DEF  = 32;
  localparam int MAX_LOG2N_DEF  = 10;
  localparam int ACC_WIDTH_DEF  = IN_WIDTH_DEF + MAX_LOG2N_DEF;
  localparam int OVF_WIDTH      = 16;

  // Exponents above the supported maximum fall back to the maximum block size.
  function automatic logic [3:0] clamp_log2n(input logic [3:0] log2n, input int max_log2n);
    if (int'(log2n) > max_log2n) return 4'(max_log2n);
    return log2n;
  endfunction

endpackage

// File: rtl/axis_hold_reg.sv
// One-deep AXI-Stream output register: loads when empty or draining, otherwise
// flags the incoming word as dropped and keeps the held word.
module axis_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             m_ready_i,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             accept_o,
  output logic             drop_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             load_ok;

  assign accept_o = valid_q & m_ready_i;
  assign load_ok  = ~valid_q | m_ready_i;
  assign drop_o   = load_valid_i & ~load_ok;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_valid_i && load_ok) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (accept_o) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;

endmodule

// File: rtl/axis_ad7763_avg.sv
// Block-averaging decimator for the AD7763 stream: sums 2^N samples and emits
// the average. Define AD7763_AVG_ROUND_EN for round-half-up instead of floor.
module axis_ad7763_avg
  import ad7763_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int MAX_LOG2N = MAX_LOG2N_DEF
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [3:0]           cfg_log2n,
  input  logic                 cfg_clear,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [OVF_WIDTH-1:0] ovf_count
);

  localparam int ACC_W = IN_WIDTH + MAX_LOG2N;
  localparam int CNT_W = MAX_LOG2N + 1;

  logic                    tready_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [3:0]              n_act_q;
  logic [OVF_WIDTH-1:0]    ovf_q;

  logic                    accept;
  logic [3:0]              n_eff;
  logic [CNT_W-1:0]        last_cnt;
  logic                    last;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] shifted;
  logic                    res_valid;
  logic                    res_drop;
  logic                    res_accept;

  assign accept = s_axis_tvalid & tready_q;

  // The first sample of a block sees the live (clamped) exponent; later samples use the latched one.
  assign n_eff    = (cnt_q == '0) ? clamp_log2n(cfg_log2n, MAX_LOG2N) : n_act_q;
  assign last_cnt = CNT_W'((CNT_W'(1) << n_eff) - CNT_W'(1));
  assign last     = accept && (cnt_q == last_cnt);
  assign sum      = acc_q + ACC_W'($signed(s_axis_tdata));

`ifdef AD7763_AVG_ROUND_EN
  assign rnd = (n_eff != 4'd0) ? (ACC_W'(1) << (n_eff - 4'd1)) : '0;
`else
  assign rnd = '0;
`endif

  assign shifted   = (sum + rnd) >>> n_eff;
  assign res_valid = last & ~cfg_clear;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tready_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      n_act_q  <= '0;
      ovf_q    <= '0;
    end else begin
      tready_q <= 1'b1;
      if (cfg_clear) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        n_act_q <= n_eff;
        if (last) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if (res_drop && ovf_q != '1) ovf_q <= ovf_q + OVF_WIDTH'(1);
    end
  end

  axis_hold_reg #(.WIDTH(OUT_WIDTH)) u_hold (
    .clk          (aclk),
    .rst_n        (aresetn),
    .load_valid_i (res_valid),
    .load_data_i  (OUT_WIDTH'(shifted)),
    .m_ready_i    (m_axis_tready),
    .m_valid_o    (m_axis_tvalid),
    .m_data_o     (m_axis_tdata),
    .accept_o     (res_accept),
    .drop_o       (res_drop)
  );

  assign s_axis_tready = tready_q;
  assign ovf_count     = ovf_q;

endmodule

// File: tb/tb_axis_ad7763_avg.sv
// Self-checking bench for axis_ad7763_avg: directed table, corner sequences and
// randomized traffic against a block-level reference model.
module tb_axis_ad7763_avg;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  cfg_log2n;
  logic        cfg_clear;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] ovf_count;

  int checks = 0;
  int errors = 0;

  axis_ad7763_avg dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_log2n     (cfg_log2n),
    .cfg_clear     (cfg_clear),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .ovf_count     (ovf_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int          log2n;
    int          nsamp;
    int          samp[8];
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input int s);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 24'(s);
    step();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    step();
  endtask

  // Average of a block of 2^n samples from its exact integer sum.
  function automatic logic [31:0] block_avg(input longint sum, input int n);
    longint r;
    r = sum;
`ifdef AD7763_AVG_ROUND_EN
    if (n > 0) r = r + (longint'(1) << (n - 1));
`endif
    return 32'(r >>> n);
  endfunction

  function automatic longint sext24(input logic [23:0] v);
    return longint'($signed(v));
  endfunction

  // Reference model state
  int          m_n;
  longint      m_blk[$];
  logic        m_valid;
  logic [31:0] m_data;
  int          m_ovf;

  vec_t vecs[6];

  initial begin
    aresetn       = 1'b0;
    cfg_log2n     = 4'd0;
    cfg_clear     = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    vecs[0] = '{2, 4, '{1, 2, 3, 6, 0, 0, 0, 0}, 32'h0000_0003};
`ifdef AD7763_AVG_ROUND_EN
    vecs[1] = '{2, 4, '{1, 2, 3, 4, 0, 0, 0, 0}, 32'h0000_0003};
    vecs[2] = '{1, 2, '{'hFFFFFF, 'hFFFFFE, 0, 0, 0, 0, 0, 0}, 32'hFFFF_FFFF};
`else
    vecs[1] = '{2, 4, '{1, 2, 3, 4, 0, 0, 0, 0}, 32'h0000_0002};
    vecs[2] = '{1, 2, '{'hFFFFFF, 'hFFFFFE, 0, 0, 0, 0, 0, 0}, 32'hFFFF_FFFE};
`endif
    vecs[3] = '{0, 1, '{'h800000, 0, 0, 0, 0, 0, 0, 0}, 32'hFF80_0000};
    vecs[4] = '{3, 8, '{'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF, 'h7FFFFF}, 32'h007F_FFFF};
    vecs[5] = '{3, 8, '{'h800000, 'h800000, 'h800000, 'h800000, 'h800000, 'h800000, 'h800000, 'h800000}, 32'hFF80_0000};

    // Reset behaviour and tready release
    step();
    step();
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_mdata",  64'(m_axis_tdata),  64'd0);
    check("rst_ovf",    64'(ovf_count),     64'd0);
    aresetn = 1'b1;
    check("tready_before_edge", 64'(s_axis_tready), 64'd0);
    step();
    check("tready_after_edge", 64'(s_axis_tready), 64'd1);

    // Directed table
    foreach (vecs[i]) begin
      cfg_log2n = 4'(vecs[i].log2n);
      for (int k = 0; k < vecs[i].nsamp; k++) begin
        if (k == vecs[i].nsamp - 1)
          check($sformatf("vec%0d_pre_valid", i), 64'(m_axis_tvalid), 64'd0);
        push(vecs[i].samp[k]);
      end
      check($sformatf("vec%0d_valid", i), 64'(m_axis_tvalid), 64'd1);
      check($sformatf("vec%0d_data", i),  64'(m_axis_tdata),  64'(vecs[i].exp));
      step();
      check($sformatf("vec%0d_drain", i), 64'(m_axis_tvalid), 64'd0);
    end

    // Mid-block exponent change: current block keeps 8, next block uses 2
    cfg_log2n = 4'd3;
    for (int k = 1; k <= 8; k++) begin
      push(k);
      if (k == 3) cfg_log2n = 4'd1;
      if (k == 7) check("cfgchg_no_early", 64'(m_axis_tvalid), 64'd0);
    end
    check("cfgchg_valid", 64'(m_axis_tvalid), 64'd1);
    check("cfgchg_data",  64'(m_axis_tdata),  64'(block_avg(36, 3)));
    push(10);
    check("cfgchg2_pending", 64'(m_axis_tvalid), 64'd0);
    push(20);
    check("cfgchg2_valid", 64'(m_axis_tvalid), 64'd1);
    check("cfgchg2_data",  64'(m_axis_tdata),  64'(block_avg(30, 1)));
    step();

    // cfg_clear on sample 5 of an N=3 block
    cfg_log2n = 4'd3;
    for (int k = 0; k < 4; k++) push(100);
    cfg_clear = 1'b1;
    push(100);
    cfg_clear = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push(k);
      if (k == 7) check("clear_no_early", 64'(m_axis_tvalid), 64'd0);
    end
    check("clear_valid", 64'(m_axis_tvalid), 64'd1);
    check("clear_data",  64'(m_axis_tdata),  64'(block_avg(36, 3)));
    step();

    // cfg_clear coinciding with a block's last sample
    cfg_log2n = 4'd1;
    push(50);
    cfg_clear = 1'b1;
    push(60);
    cfg_clear = 1'b0;
    check("clear_last_none", 64'(m_axis_tvalid), 64'd0);

    // Reset mid-block loses the partial block
    cfg_log2n = 4'd2;
    push(1000);
    push(1000);
    do_reset();
    for (int k = 0; k < 4; k++) push(4);
    check("rstmid_valid", 64'(m_axis_tvalid), 64'd1);
    check("rstmid_data",  64'(m_axis_tdata),  64'd4);
    step();

    // Pass-through with stalled output: first word held, rest dropped, counter saturates
    cfg_log2n     = 4'd0;
    m_axis_tready = 1'b0;
    for (int k = 10; k < 15; k++) push(k);
    check("ovf_held_valid", 64'(m_axis_tvalid), 64'd1);
    check("ovf_held_data",  64'(m_axis_tdata),  64'd10);
    check("ovf_count4",     64'(ovf_count),     64'd4);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 24'd77;
    for (int k = 0; k < 65540; k++) step();
    s_axis_tvalid = 1'b0;
    check("ovf_sat",      64'(ovf_count),    64'hFFFF);
    check("ovf_sat_data", 64'(m_axis_tdata), 64'd10);
    m_axis_tready = 1'b1;
    step();
    check("ovf_drain",    64'(m_axis_tvalid), 64'd0);
    check("ovf_sat_keep", 64'(ovf_count),     64'hFFFF);

    // Randomized traffic against the block-level model
    do_reset();
    m_n = 0;
    m_blk.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        res_v;
      logic [31:0] res_d;
      longint      sum;
      if ($urandom_range(0, 39) == 0) cfg_log2n = 4'($urandom_range(11, 15));
      else if ($urandom_range(0, 15) == 0) cfg_log2n = 4'($urandom_range(0, 3));
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = 24'($urandom);
      m_axis_tready = ($urandom_range(0, 2) != 0);
      cfg_clear     = ($urandom_range(0, 49) == 0);

      res_v = 1'b0;
      res_d = '0;
      if (cfg_clear) begin
        m_blk.delete();
      end else if (s_axis_tvalid) begin
        if (m_blk.size() == 0) m_n = (int'(cfg_log2n) > 10) ? 10 : int'(cfg_log2n);
        m_blk.push_back(sext24(s_axis_tdata));
        if (m_blk.size() == (1 << m_n)) begin
          sum = 0;
          foreach (m_blk[j]) sum += m_blk[j];
          res_v = 1'b1;
          res_d = block_avg(sum, m_n);
          m_blk.delete();
        end
      end
      if (res_v && (!m_valid || m_axis_tready)) begin
        m_valid = 1'b1;
        m_data  = res_d;
      end else if (res_v) begin
        if (m_ovf < 65535) m_ovf++;
      end else if (m_valid && m_axis_tready) begin
        m_valid = 1'b0;
      end

      step();
      check("rnd_valid", 64'(m_axis_tvalid), 64'(m_valid));
      check("rnd_data",  64'(m_axis_tdata),  64'(m_data));
      check("rnd_ovf",   64'(ovf_count),     64'(m_ovf));
    end
    s_axis_tvalid = 1'b0;
    cfg_clear     = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_ad7763_avg.md
# axis_ad7763_avg

Block-averaging decimator directly downstream of the AD7763 AXI-Stream output. Accepts signed 24-bit ADC samples on the ADC stream clock, sums blocks of 2^N consecutive samples, and emits one sign-extended average per block on a 32-bit AXI-Stream master. The ADC cannot be back-pressured, so the input is never stalled. Results that cannot be delivered are dropped and counted.

## Interface
Parameters:
- IN_WIDTH, 24, input sample width (signed, two's complement)
- OUT_WIDTH, 32, output word width; must be ≥ IN_WIDTH
- MAX_LOG2N, 10, largest supported block exponent

Ports:
- aclk  in  1  stream clock (ADC clock domain)
- aresetn  in  1  reset; synchronous, active-low
- cfg_log2n  in  4  block exponent N; block length 2^N; values > MAX_LOG2N are clamped to MAX_LOG2N
- cfg_clear  in  1  synchronous abandon of the partial block
- s_axis_tdata  in  IN_WIDTH  ADC sample
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  registered; 0 in reset, 1 on every cycle after reset release
- m_axis_tdata  out  OUT_WIDTH  averaged sample, sign-extended
- m_axis_tvalid  out  1  result valid
- m_axis_tready  in  1  downstream ready
- ovf_count  out  16  dropped-result counter, saturating

## Operation
- A sample is accepted on any edge with s_axis_tvalid & s_axis_tready.
- Accumulator width is IN_WIDTH+MAX_LOG2N (signed). Sample counter width is MAX_LOG2N+1.
- Block length latch:
  - The active exponent n_act is latched from the clamped cfg_log2n when an accepted sample arrives with count==0, i.e. the first sample of a block.
  - A mid-block change of cfg_log2n has no effect until the next block.
- Accumulation:
  - On an accepted sample that is not the last of its block: acc ← acc + sext(sample), count ← count+1.
- Last sample of a block (count == 2^n_act − 1):
  - sum = acc + sext(sample).
  - result = sum >>> n_act (arithmetic shift), sign-extended to OUT_WIDTH.
  - acc ← 0, count ← 0.
- n_act = 0 is pass-through: every sample is a block, and the output equals the sign-extended sample.
- One-deep output register:
  - The result is loaded if m_axis_tvalid==0, or if m_axis_tvalid & m_axis_tready in the same cycle (simultaneous drain and load).
  - Otherwise the new result is discarded, the held word is kept unchanged, and ovf_count increments, saturating at 0xFFFF.
- Output handshake: m_axis_tvalid falls after a handshake unless a new result is loaded on that same edge. m_axis_tdata is stable while m_axis_tvalid & !m_axis_tready.
- cfg_clear:
  - acc ← 0, count ← 0. The sample accepted in that cycle is discarded.
  - The output register and ovf_count are untouched.
- States are implicit: ACCUM (count>0) / IDLE (count==0). No other FSM.

## Timing
- Reset (aresetn low at an edge) sets: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, ovf_count=0, acc=0, count=0, n_act=0.
- s_axis_tready rises on the first edge with aresetn high.
- Latency: m_axis_tvalid is high in the cycle after the edge that accepted the block's last sample.
- Throughput: one sample per cycle sustained.
- Reset mid-block: the partial block is lost and no output is produced.
- cfg_clear on the same edge as a block's last sample: clear wins and no result is produced.

## Configuration
- Macro AD7763_AVG_ROUND_EN.
- Defined: for n_act>0, 2^(n_act−1) is added to sum before the shift (round half up toward +∞).
- Undefined: plain arithmetic shift (floor).
- For n_act=0 both variants are identical.

## Structure
- Package ad7763_pkg holds:
  - IN_WIDTH/OUT_WIDTH/MAX_LOG2N defaults
  - accumulator width constant
  - clamp_log2n function
  - ovf counter width (16)
- Sub-module axis_hold_reg: one-deep AXI-Stream output register with load, accept and drop signals. The top level owns the accumulator, counter and ovf_count.

## Test plan
- Reset release: s_axis_tready 0→1 one edge after aresetn high. All outputs are 0 during reset.
- N=2, inputs 1,2,3,6: m_axis_tdata=0x00000003 one cycle after the 4th sample. With rounding, inputs 1,2,3,4 (sum 10) → 3; without rounding → 2.
- N=1, inputs 0xFFFFFF, 0xFFFFFE (−1, −2): output 0xFFFFFFFE (floor) or 0xFFFFFFFF (rounded).
- N=0, m_axis_tready held 0, 5 consecutive samples: first sample is held, ovf_count=4. Hold ovf at 0xFFFF and push more → stays 0xFFFF.
- N=3 block in progress, cfg_log2n changed to 1 after sample 3: the current block still takes 8 samples, and the next block takes 2.
- cfg_clear asserted at sample 5 of an N=3 block: no output; the next output averages the following 8 samples only.
